// File: rtl/mc_rst_sequencer_if.sv
// Status/reset bundle between the MIG/PHY side and the per-channel bridges.
// The sequencer takes the slave view; whoever drives PHY status takes the master view.
interface mc_rst_sequencer_if #(
  parameter int NUM_CH = 2
);
  logic              ext_rst_req;
  logic              phy_rst_in;
  logic [NUM_CH-1:0] calib_done_in;
  logic [NUM_CH-1:0] afifo_rst_out;
  logic [NUM_CH-1:0] ch_rst_out;
  logic              all_ready;
  logic              timeout_err;
  logic [2:0]        state_out;

  modport master (
    output ext_rst_req, phy_rst_in, calib_done_in,
    input  afifo_rst_out, ch_rst_out, all_ready, timeout_err, state_out
  );

  modport slave (
    input  ext_rst_req, phy_rst_in, calib_done_in,
    output afifo_rst_out, ch_rst_out, all_ready, timeout_err, state_out
  );
endinterface

// File: rtl/mc_rst_sequencer.sv
// Multi-channel memory-controller reset sequencer: waits for PHY reset release and
// calibration, holds a programmable delay, then releases channels one by one.
module mc_rst_sequencer #(
  parameter int               NUM_CH        = 2,
  parameter int               CNT_W         = 32,
  parameter logic [CNT_W-1:0] RELEASE_DELAY = 'h1ff,
  parameter int               STAGGER       = 16,
  parameter int               TIMEOUT       = 1 << 20,
  parameter int               SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  mc_rst_sequencer_if.slave  bus
);

  localparam int               IDX_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE        = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] STAGGER_RELOAD = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_WAIT_PHY   = 3'd1,
    S_WAIT_CALIB = 3'd2,
    S_DELAY      = 3'd3,
    S_STAGGER    = 3'd4,
    S_RUN        = 3'd5,
    S_ERROR      = 3'd6
  } state_e;

  logic [SYNC_STAGES-1:0]             r_phy_sync;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_cal_sync;

  state_e            r_state;
  logic [CNT_W-1:0]  r_tmr;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [NUM_CH-1:0] r_chan_rst;
  logic              r_all_ready;
  logic              r_timeout_err;

  logic              w_phy_rst_s;
  logic [NUM_CH-1:0] w_calib_s;
  logic              w_calib_all;
  logic              w_seq_active;
  logic              w_seq_abort;
  logic [IDX_W-1:0]  w_next_idx;

  // Synchronisers reset to the "PHY in reset, nothing calibrated" view so a
  // fresh reset can never be mistaken for a calibrated PHY.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phy_sync <= '1;
      r_cal_sync <= '0;
    end else begin
      r_phy_sync <= {r_phy_sync[SYNC_STAGES-2:0], bus.phy_rst_in};
      r_cal_sync <= {r_cal_sync[SYNC_STAGES-2:0], bus.calib_done_in};
    end
  end

  assign w_phy_rst_s  = r_phy_sync[SYNC_STAGES-1];
  assign w_calib_s    = r_cal_sync[SYNC_STAGES-1];
  assign w_calib_all  = &w_calib_s;
  assign w_seq_active = (r_state == S_DELAY) || (r_state == S_STAGGER) || (r_state == S_RUN);
  assign w_seq_abort  = w_phy_rst_s || !w_calib_all;
  assign w_next_idx   = r_idx + IDX_ONE;

  always_ff @(posedge clk) begin
    if (rst || bus.ext_rst_req) begin
      r_state       <= S_RESET;
      r_tmr         <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_chan_rst    <= '1;
      r_all_ready   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_seq_active && w_seq_abort) begin
      // Losing PHY or any calibration once sequencing has begun restarts everything.
      r_state     <= S_WAIT_PHY;
      r_idx       <= '0;
      r_chan_rst  <= '1;
      r_all_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_RESET: begin
          r_state    <= S_WAIT_PHY;
          r_chan_rst <= '1;
        end
        S_WAIT_PHY: begin
          if (!w_phy_rst_s) begin
            r_state <= S_WAIT_CALIB;
            r_tmr   <= '0;
          end
        end
        S_WAIT_CALIB: begin
          r_tmr <= r_tmr + CNT_ONE;
          // Priority: PHY reset, then calibration, then timeout.
          if (w_phy_rst_s) begin
            r_state <= S_WAIT_PHY;
          end else if (w_calib_all) begin
            r_state <= S_DELAY;
            r_cnt   <= RELEASE_DELAY;
          end else if (r_tmr == TIMEOUT_LAST) begin
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
            r_chan_rst    <= '1;
          end
        end
        S_DELAY: begin
          if (r_cnt == '0) begin
            r_state       <= S_STAGGER;
            r_idx         <= '0;
            r_cnt         <= STAGGER_RELOAD;
            r_chan_rst[0] <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_STAGGER: begin
          if (r_idx == LAST_IDX) begin
            r_state     <= S_RUN;
            r_all_ready <= 1'b1;
          end else if (r_cnt == '0) begin
            r_idx                  <= w_next_idx;
            r_chan_rst[w_next_idx] <= 1'b0;
            r_cnt                  <= STAGGER_RELOAD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_RUN: begin
          r_all_ready <= 1'b1;
        end
        S_ERROR: begin
          r_chan_rst    <= '1;
          r_timeout_err <= 1'b1;
        end
        default: begin
          r_state    <= S_RESET;
          r_chan_rst <= '1;
        end
      endcase
    end
  end

  // Both reset buses come from one register, so they cannot disagree.
  assign bus.afifo_rst_out = r_chan_rst;
  assign bus.ch_rst_out    = r_chan_rst;
  assign bus.all_ready     = r_all_ready;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.state_out     = r_state;

endmodule

// File: tb/tb_mc_rst_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus, checked every cycle
// against a timestamp-based model of the reset sequence.
module tb_mc_rst_sequencer;

  localparam int NUM_CH = 2;
  localparam int RD     = 8;
  localparam int ST     = 4;
  localparam int TO     = 64;
  localparam int SS     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_rst_sequencer_if #(.NUM_CH(NUM_CH)) bus ();
  mc_rst_sequencer_if #(.NUM_CH(1))      bus1 ();

  mc_rst_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(32), .RELEASE_DELAY(32'd8),
    .STAGGER(ST), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mc_rst_sequencer #(
    .NUM_CH(1), .CNT_W(32), .RELEASE_DELAY(32'd0),
    .STAGGER(ST), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus1.ext_rst_req   = bus.ext_rst_req;
  assign bus1.phy_rst_in    = bus.phy_rst_in;
  assign bus1.calib_done_in = bus.calib_done_in[0:0];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -1;

  // Reference model: the sequence is described by when it started, not by counters.
  typedef enum {M_RESET, M_WPHY, M_WCAL, M_SEQ, M_ERR} model_mode_e;
  typedef struct {
    bit       r;
    bit       phy;
    bit [1:0] cal;
  } smp_t;

  model_mode_e m_mode = M_RESET;
  int          m_wc   = 0;
  int          m_seq  = 0;
  smp_t        hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit any_req, input smp_t cur);
    bit phy_s, cal_ok, synced_rst;
    synced_rst = 1'b0;
    foreach (hist[j]) if (hist[j].r) synced_rst = 1'b1;
    phy_s  = synced_rst ? 1'b1 : hist[0].phy;
    cal_ok = synced_rst ? 1'b0 : (&hist[0].cal);
    hist.push_back(cur);
    if (hist.size() > SS) void'(hist.pop_front());

    if (any_req) m_mode = M_RESET;
    else begin
      case (m_mode)
        M_RESET: m_mode = M_WPHY;
        M_WPHY:  if (!phy_s) begin m_mode = M_WCAL; m_wc = cyc; end
        M_WCAL: begin
          if (phy_s)                 m_mode = M_WPHY;
          else if (cal_ok)           begin m_mode = M_SEQ; m_seq = cyc; end
          else if (cyc - m_wc == TO) m_mode = M_ERR;
        end
        M_SEQ:   if (phy_s || !cal_ok) m_mode = M_WPHY;
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    logic [1:0] emask;
    int es, e, last;
    bit eready, eterr;
    emask = 2'b11; eready = 1'b0; eterr = 1'b0; es = 0;
    case (m_mode)
      M_RESET: es = 0;
      M_WPHY:  es = 1;
      M_WCAL:  es = 2;
      M_ERR:   begin es = 6; eterr = 1'b1; end
      default: begin
        e    = cyc - m_seq;
        last = RD + 1 + (NUM_CH - 1) * ST;
        for (int k = 0; k < NUM_CH; k++)
          if (e >= RD + 1 + k * ST) emask[k] = 1'b0;
        es     = (e <= RD) ? 3 : ((e > last) ? 5 : 4);
        eready = (e > last);
      end
    endcase
    check("state", bus.state_out, es);
    check("ch_rst", bus.ch_rst_out, emask);
    check("afifo_rst", bus.afifo_rst_out, emask);
    check("all_ready", bus.all_ready, eready);
    check("timeout_err", bus.timeout_err, eterr);
  endtask

  task automatic step();
    smp_t cur;
    bit   any_req;
    cur.r   = rst;
    cur.phy = bus.phy_rst_in;
    cur.cal = bus.calib_done_in;
    any_req = rst | bus.ext_rst_req;
    @(posedge clk);
    cyc++;
    model_edge(any_req, cur);
    @(negedge clk);
    check_model();
  endtask

  // Test-plan schedule; edge numbers are relative to the first reset edge.
  task automatic run_plan(input int sel, input int pulse_at, input int ext_at, input int len);
    for (int rel = 0; rel < len; rel++) begin
      rst               = (rel <= 2);
      bus.phy_rst_in    = (rel <= 5) || (rel == pulse_at);
      bus.calib_done_in = (rel >= 11) ? 2'b11 : 2'b00;
      bus.ext_rst_req   = (rel == ext_at);
      step();
      if (sel == 1) begin
        if (rel == 13) check("nom_delay_entry", bus.state_out, 3);
        if (rel == 21) check("nom_ch0_held", bus.ch_rst_out, 2'b11);
        if (rel == 22) check("nom_ch0_release", bus.ch_rst_out, 2'b10);
        if (rel == 26) check("nom_ch1_release", bus.ch_rst_out, 2'b00);
        if (rel == 26) check("nom_ready_not_yet", bus.all_ready, 0);
        if (rel == 27) check("nom_ready", bus.all_ready, 1);
        if (rel == 27) check("nom_run", bus.state_out, 5);
        if (rel == 13) check("c1_delay", bus1.state_out, 3);
        if (rel == 13) check("c1_held", bus1.ch_rst_out, 1);
        if (rel == 14) check("c1_release", bus1.ch_rst_out, 0);
        if (rel == 14) check("c1_ready_not_yet", bus1.all_ready, 0);
        if (rel == 15) check("c1_ready", bus1.all_ready, 1);
        if (rel == 15) check("c1_run", bus1.state_out, 5);
      end
      if (sel == 3) begin
        if (rel == 19) check("phy_in_delay_state", bus.state_out, 1);
        if (rel == 22) check("phy_in_delay_held", bus.ch_rst_out, 2'b11);
        if (rel == 29) check("phy_redelay_held", bus.ch_rst_out, 2'b11);
        if (rel == 30) check("phy_redelay_release", bus.ch_rst_out, 2'b10);
      end
      if (sel == 5) begin
        if (rel == 24) check("ext_pre_ch", bus.ch_rst_out, 2'b10);
        if (rel == 25) check("ext_ch_rst", bus.ch_rst_out, 2'b11);
        if (rel == 25) check("ext_afifo_rst", bus.afifo_rst_out, 2'b11);
        if (rel == 25) check("ext_state", bus.state_out, 0);
      end
    end
  endtask

  task automatic run_timeout(input int cal_at, input int len);
    for (int rel = 0; rel < len; rel++) begin
      rst               = (rel <= 2);
      bus.ext_rst_req   = 1'b0;
      bus.phy_rst_in    = (rel <= 5);
      bus.calib_done_in = (rel >= cal_at) ? 2'b11 : 2'b01;
      step();
      if (cal_at > len) begin
        if (rel == 71) check("to_before", bus.timeout_err, 0);
        if (rel == 71) check("to_before_state", bus.state_out, 2);
        if (rel == 72) check("to_err", bus.timeout_err, 1);
        if (rel == 72) check("to_state", bus.state_out, 6);
        if (rel == 72) check("to_resets", bus.ch_rst_out, 2'b11);
      end else begin
        if (rel == 72) check("tie_calib_wins", bus.state_out, 3);
        if (rel == 72) check("tie_no_err", bus.timeout_err, 0);
      end
    end
  endtask

  initial begin
    int r0;
    rst               = 1'b1;
    bus.ext_rst_req   = 1'b0;
    bus.phy_rst_in    = 1'b1;
    bus.calib_done_in = 2'b00;
    for (int j = 0; j < SS; j++) hist.push_back('{r: 1'b1, phy: 1'b1, cal: 2'b00});

    // Nominal bring-up, also checks the single-channel zero-delay instance.
    run_plan(1, -1, -1, 40);
    check("reset_seen_ready", bus.all_ready, 1);

    // Calibration loss in RUN, then recovery with the nominal relative timing.
    bus.calib_done_in = 2'b01;
    for (int i = 0; i < 3; i++) step();
    check("loss_resets", bus.ch_rst_out, 2'b11);
    check("loss_ready", bus.all_ready, 0);
    check("loss_state", bus.state_out, 1);
    bus.calib_done_in = 2'b11;
    r0 = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cyc == r0 + 10) check("recov_ch0_held", bus.ch_rst_out, 2'b11);
      if (cyc == r0 + 11) check("recov_ch0", bus.ch_rst_out, 2'b10);
      if (cyc == r0 + 16) check("recov_ready", bus.all_ready, 1);
    end

    run_plan(3, 17, -1, 45);
    run_plan(5, -1, 25, 45);

    // Timeout, sticky error, then exit only via ext_rst_req.
    run_timeout(1000, 82);
    bus.calib_done_in = 2'b11;
    for (int i = 0; i < 10; i++) step();
    check("err_sticky", bus.state_out, 6);
    bus.ext_rst_req = 1'b1;
    step();
    check("err_clear", bus.timeout_err, 0);
    check("err_clear_state", bus.state_out, 0);
    bus.ext_rst_req = 1'b0;

    // Calibration arriving on the timeout cycle.
    run_timeout(70, 80);

    // Random stimulus against the model.
    for (int i = 0; i < 2500; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.ext_rst_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) bus.phy_rst_in = ~bus.phy_rst_in;
      if ($urandom_range(0, 29) == 0) bus.calib_done_in = 2'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
